// File: rtl/mem_port_arbiter_if.sv
// Bundles the LSU load request, ROB store commit, data-memory port and load completion signals.
// The slave modport is the arbiter's view. The master modport is the surrounding pipeline's view.
interface mem_port_arbiter_if #(
    parameter int SQ_DEPTH = 4
);
    logic                      flush;

    logic                      ld_valid;
    logic [31:0]               ld_addr;
    logic [2:0]                ld_func3;
    logic [7:0]                ld_phy;
    logic [31:0]               ld_inst_num;
    logic                      ld_ready;

    logic                      st_valid;
    logic [31:0]               st_addr;
    logic [31:0]               st_data;
    logic [2:0]                st_func3;
    logic [31:0]               st_inst_num;
    logic                      st_ready;

    logic                      mem_read;
    logic                      mem_write;
    logic [31:0]               mem_addr;
    logic [31:0]               mem_wdata;
    logic [2:0]                mem_func3;
    logic [31:0]               mem_rdata;

    logic                      ld_done;
    logic [7:0]                ld_done_phy;
    logic [31:0]               ld_done_inst_num;
    logic [31:0]               ld_done_data;

    logic [$clog2(SQ_DEPTH):0] sq_count;

    modport slave (
        input  flush,
        input  ld_valid, ld_addr, ld_func3, ld_phy, ld_inst_num,
        output ld_ready,
        input  st_valid, st_addr, st_data, st_func3, st_inst_num,
        output st_ready,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata,
        output ld_done, ld_done_phy, ld_done_inst_num, ld_done_data,
        output sq_count
    );

    modport master (
        output flush,
        output ld_valid, ld_addr, ld_func3, ld_phy, ld_inst_num,
        input  ld_ready,
        output st_valid, st_addr, st_data, st_func3, st_inst_num,
        input  st_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_func3,
        output mem_rdata,
        input  ld_done, ld_done_phy, ld_done_inst_num, ld_done_data,
        input  sq_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one data-memory port between speculative loads and an in-order committed-store queue.
// The grant issues one cycle later and the load completes two cycles after its grant. Back-pressure is ld_ready (combinational) and st_ready (taken from the registered count).
module mem_port_arbiter #(
    parameter int SQ_DEPTH     = 4,
    parameter int DRAIN_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave io
);
    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(SQ_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(DRAIN_THRESH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  func3;
        logic [31:0] inst_num;
    } sq_entry_t;

    sq_entry_t              sq_mem [SQ_DEPTH];
    logic [SQ_DEPTH-1:0]    sq_vld;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          cnt;

    logic                   enq;
    logic                   deq;
    logic                   alias_hit;
    logic                   conflict;
    logic                   drain;
    logic                   ld_grant;

    logic                   p1_vld;
    logic [7:0]             p1_phy;
    logic [31:0]            p1_inst_num;

    sq_entry_t              head_entry;
    logic                   unused_head_inst;

    assign head_entry       = sq_mem[head];
    assign unused_head_inst = ^head_entry.inst_num;

    // Word-granular alias check against every live queue entry
    always_comb begin
        alias_hit = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (sq_vld[i] && (sq_mem[i].addr[31:2] == io.ld_addr[31:2])) begin
                alias_hit = 1'b1;
            end
        end
    end

    assign conflict = io.ld_valid && alias_hit;
    assign drain    = (cnt >= THRESH_C) || conflict;
    // A flush or drain pressure steals the slot from the load. Otherwise any free slot goes to the head store.
    assign ld_grant = io.ld_valid && !io.flush && !drain;
    assign deq      = (cnt != '0) && !ld_grant;

    assign io.st_ready     = (cnt < DEPTH_C);
    assign enq             = io.st_valid && io.st_ready;
    assign io.ld_ready     = ld_grant;
    assign io.sq_count     = cnt;
    assign io.ld_done_data = io.mem_rdata;

    // Payload storage carries no reset; sq_vld alone defines occupancy.
    always_ff @(posedge clk) begin
        if (enq) begin
            sq_mem[tail] <= '{addr:     io.st_addr,
                              data:     io.st_data,
                              func3:    io.st_func3,
                              inst_num: io.st_inst_num};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head                <= '0;
            tail                <= '0;
            cnt                 <= '0;
            sq_vld              <= '0;
            io.mem_read         <= 1'b0;
            io.mem_write        <= 1'b0;
            io.mem_addr         <= '0;
            io.mem_wdata        <= '0;
            io.mem_func3        <= '0;
            p1_vld              <= 1'b0;
            p1_phy              <= '0;
            p1_inst_num         <= '0;
            io.ld_done          <= 1'b0;
            io.ld_done_phy      <= '0;
            io.ld_done_inst_num <= '0;
        end else begin
            // Head and tail only coincide when the queue is empty or full, so enq and deq never hit the same slot
            if (enq) begin
                tail         <= tail + PW'(1);
                sq_vld[tail] <= 1'b1;
            end
            if (deq) begin
                head         <= head + PW'(1);
                sq_vld[head] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            if (ld_grant) begin
                io.mem_read  <= 1'b1;
                io.mem_write <= 1'b0;
                io.mem_addr  <= io.ld_addr;
                io.mem_func3 <= io.ld_func3;
            end else if (deq) begin
                io.mem_read  <= 1'b0;
                io.mem_write <= 1'b1;
                io.mem_addr  <= head_entry.addr;
                io.mem_wdata <= head_entry.data;
                io.mem_func3 <= head_entry.func3;
            end else begin
                io.mem_read  <= 1'b0;
                io.mem_write <= 1'b0;
            end

            p1_vld <= ld_grant;
            if (ld_grant) begin
                p1_phy      <= io.ld_phy;
                p1_inst_num <= io.ld_inst_num;
            end

            // A load in flight while flush is high is dropped; the memory read still happens.
            io.ld_done <= p1_vld && !io.flush;
            if (p1_vld && !io.flush) begin
                io.ld_done_phy      <= p1_phy;
                io.ld_done_inst_num <= p1_inst_num;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. u_dut uses the default threshold.
// u_full raises the threshold to SQ_DEPTH so that the queue can actually fill.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if #(.SQ_DEPTH(4)) io  ();
    mem_port_arbiter_if #(.SQ_DEPTH(4)) io2 ();

    mem_port_arbiter #(.SQ_DEPTH(4), .DRAIN_THRESH(3)) u_dut  (.clk(clk), .rst(rst), .io(io));
    mem_port_arbiter #(.SQ_DEPTH(4), .DRAIN_THRESH(4)) u_full (.clk(clk), .rst(rst), .io(io2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        io.flush = 0;  io.ld_valid = 0; io.ld_addr = 0; io.ld_func3 = 0; io.ld_phy = 0; io.ld_inst_num = 0;
        io.st_valid = 0; io.st_addr = 0; io.st_data = 0; io.st_func3 = 0; io.st_inst_num = 0; io.mem_rdata = 0;
        io2.flush = 0; io2.ld_valid = 0; io2.ld_addr = 0; io2.ld_func3 = 0; io2.ld_phy = 0; io2.ld_inst_num = 0;
        io2.st_valid = 0; io2.st_addr = 0; io2.st_data = 0; io2.st_func3 = 0; io2.st_inst_num = 0; io2.mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step(); step();
        rst = 1'b0;
        mid();
        n_tests++; if (io.st_ready !== 1'b1) begin n_fail++; $display("FAIL reset.st_ready got %0b want 1", io.st_ready); end
        n_tests++; if (io.sq_count !== 3'd0) begin n_fail++; $display("FAIL reset.sq_count got %0d want 0", io.sq_count); end
        n_tests++; if (io.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset.ld_ready got %0b want 0", io.ld_ready); end
        n_tests++; if ({io.mem_read, io.mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset.strobes got %b want 00", {io.mem_read, io.mem_write}); end
        n_tests++; if ({io.mem_addr, io.mem_wdata, io.mem_func3} !== 67'd0) begin n_fail++; $display("FAIL reset.mem_bus got %h/%h/%h want 0", io.mem_addr, io.mem_wdata, io.mem_func3); end
        n_tests++; if ({io.ld_done, io.ld_done_phy, io.ld_done_inst_num} !== 41'd0) begin n_fail++; $display("FAIL reset.ld_done got %b/%h/%h want 0", io.ld_done, io.ld_done_phy, io.ld_done_inst_num); end
        n_tests++; if (io2.st_ready !== 1'b1) begin n_fail++; $display("FAIL reset.full_st_ready got %0b want 1", io2.st_ready); end
    endtask

    task automatic test_load_only();
        step();
        io.ld_valid = 1; io.ld_addr = 32'h100; io.ld_phy = 8'h12; io.ld_inst_num = 32'd7; io.ld_func3 = 3'b010;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_only.ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.ld_valid = 0;
        mid();
        n_tests++; if ({io.mem_read, io.mem_write} !== 2'b10) begin n_fail++; $display("FAIL load_only.strobes got %b want 10", {io.mem_read, io.mem_write}); end
        n_tests++; if (io.mem_addr !== 32'h100) begin n_fail++; $display("FAIL load_only.mem_addr got %h want 100", io.mem_addr); end
        n_tests++; if (io.mem_func3 !== 3'b010) begin n_fail++; $display("FAIL load_only.mem_func3 got %0d want 2", io.mem_func3); end
        n_tests++; if (io.ld_done !== 1'b0) begin n_fail++; $display("FAIL load_only.early_done got %0b want 0", io.ld_done); end
        step();
        io.mem_rdata = 32'hCAFE_F00D;
        mid();
        n_tests++; if (io.ld_done !== 1'b1) begin n_fail++; $display("FAIL load_only.ld_done got %0b want 1", io.ld_done); end
        n_tests++; if (io.ld_done_phy !== 8'h12) begin n_fail++; $display("FAIL load_only.phy got %h want 12", io.ld_done_phy); end
        n_tests++; if (io.ld_done_inst_num !== 32'd7) begin n_fail++; $display("FAIL load_only.inst got %0d want 7", io.ld_done_inst_num); end
        n_tests++; if (io.ld_done_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL load_only.data got %h want cafef00d", io.ld_done_data); end
        n_tests++; if (io.mem_read !== 1'b0) begin n_fail++; $display("FAIL load_only.idle_read got %0b want 0", io.mem_read); end
        step();
        mid();
        n_tests++; if (io.ld_done !== 1'b0) begin n_fail++; $display("FAIL load_only.pulse got %0b want 0", io.ld_done); end
    endtask

    task automatic test_loads_over_stores();
        step();
        io.ld_valid = 1; io.ld_addr = 32'h300; io.ld_phy = 8'h01;
        io.st_valid = 1; io.st_addr = 32'h200; io.st_data = 32'h1111_1111; io.st_func3 = 3'b010;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL lds_win.c0_ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.st_addr = 32'h204; io.st_data = 32'h2222_2222;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL lds_win.c1_ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.st_valid = 0;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL lds_win.c2_ld_ready got %0b want 1", io.ld_ready); end
        n_tests++; if (io.sq_count !== 3'd2) begin n_fail++; $display("FAIL lds_win.sq_count got %0d want 2", io.sq_count); end
        step();
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL lds_win.c3_ld_ready got %0b want 1", io.ld_ready); end
        n_tests++; if ({io.mem_read, io.mem_write} !== 2'b10) begin n_fail++; $display("FAIL lds_win.c3_strobes got %b want 10", {io.mem_read, io.mem_write}); end
        step();
        io.ld_valid = 0;
        mid();
        n_tests++; if (io.ld_ready !== 1'b0) begin n_fail++; $display("FAIL lds_win.idle_ld_ready got %0b want 0", io.ld_ready); end
        step();
        mid();
        n_tests++; if ({io.mem_write, io.mem_addr, io.mem_wdata} !== {1'b1, 32'h200, 32'h1111_1111}) begin n_fail++; $display("FAIL lds_win.st0 got w=%0b a=%h d=%h want 1/200/11111111", io.mem_write, io.mem_addr, io.mem_wdata); end
        n_tests++; if (io.sq_count !== 3'd1) begin n_fail++; $display("FAIL lds_win.sq_after1 got %0d want 1", io.sq_count); end
        step();
        mid();
        n_tests++; if ({io.mem_write, io.mem_addr, io.mem_wdata} !== {1'b1, 32'h204, 32'h2222_2222}) begin n_fail++; $display("FAIL lds_win.st1 got w=%0b a=%h d=%h want 1/204/22222222", io.mem_write, io.mem_addr, io.mem_wdata); end
        n_tests++; if (io.sq_count !== 3'd0) begin n_fail++; $display("FAIL lds_win.sq_after2 got %0d want 0", io.sq_count); end
        step();
        mid();
        n_tests++; if ({io.mem_read, io.mem_write, io.mem_addr} !== {2'b00, 32'h204}) begin n_fail++; $display("FAIL lds_win.idle_hold got r=%0b w=%0b a=%h want 0/0/204", io.mem_read, io.mem_write, io.mem_addr); end
    endtask

    task automatic test_drain_thresh();
        step();
        io.ld_valid = 1; io.ld_addr = 32'h600; io.ld_phy = 8'h02;
        io.st_valid = 1; io.st_addr = 32'h500; io.st_data = 32'h55;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain.c0_ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.st_addr = 32'h504;
        mid();
        step();
        io.st_addr = 32'h508;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain.cnt2_ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.st_valid = 0;
        mid();
        n_tests++; if (io.sq_count !== 3'd3) begin n_fail++; $display("FAIL drain.sq_count got %0d want 3", io.sq_count); end
        n_tests++; if (io.ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain.thresh_ld_ready got %0b want 0", io.ld_ready); end
        step();
        mid();
        n_tests++; if ({io.mem_write, io.mem_addr} !== {1'b1, 32'h500}) begin n_fail++; $display("FAIL drain.store got w=%0b a=%h want 1/500", io.mem_write, io.mem_addr); end
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain.resume_ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.ld_valid = 0;
        mid();
        n_tests++; if ({io.mem_read, io.mem_addr} !== {1'b1, 32'h600}) begin n_fail++; $display("FAIL drain.load got r=%0b a=%h want 1/600", io.mem_read, io.mem_addr); end
        step();
        mid();
        n_tests++; if (io.mem_addr !== 32'h504) begin n_fail++; $display("FAIL drain.order1 got %h want 504", io.mem_addr); end
        step();
        mid();
        n_tests++; if ({io.mem_addr, io.sq_count} !== {32'h508, 3'd0}) begin n_fail++; $display("FAIL drain.order2 got a=%h cnt=%0d want 508/0", io.mem_addr, io.sq_count); end
    endtask

    task automatic test_conflict();
        step();
        io.ld_valid = 1; io.ld_addr = 32'h700; io.ld_phy = 8'h03;
        io.st_valid = 1; io.st_addr = 32'h400; io.st_data = 32'h44;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL conflict.c0_ld_ready got %0b want 1", io.ld_ready); end
        step();
        io.st_valid = 0; io.ld_addr = 32'h402;
        mid();
        n_tests++; if (io.ld_ready !== 1'b0) begin n_fail++; $display("FAIL conflict.blocked got %0b want 0", io.ld_ready); end
        step();
        mid();
        n_tests++; if ({io.mem_write, io.mem_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL conflict.store_first got w=%0b a=%h want 1/400", io.mem_write, io.mem_addr); end
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL conflict.released got %0b want 1", io.ld_ready); end
        step();
        io.ld_valid = 0;
        mid();
        n_tests++; if ({io.mem_read, io.mem_write, io.mem_addr} !== {2'b10, 32'h402}) begin n_fail++; $display("FAIL conflict.load_after got r=%0b w=%0b a=%h want 1/0/402", io.mem_read, io.mem_write, io.mem_addr); end
    endtask

    task automatic test_flush();
        step();
        io.ld_valid = 1; io.ld_addr = 32'h800; io.ld_phy = 8'h33;
        io.st_valid = 1; io.st_addr = 32'h900; io.st_data = 32'h99;
        mid();
        n_tests++; if (io.ld_ready !== 1'b1) begin n_fail++; $display("FAIL flush.grant got %0b want 1", io.ld_ready); end
        step();
        io.st_valid = 0; io.flush = 1; io.ld_addr = 32'h804;
        mid();
        n_tests++; if (io.ld_ready !== 1'b0) begin n_fail++; $display("FAIL flush.no_grant got %0b want 0", io.ld_ready); end
        n_tests++; if ({io.mem_read, io.mem_addr} !== {1'b1, 32'h800}) begin n_fail++; $display("FAIL flush.read_issued got r=%0b a=%h want 1/800", io.mem_read, io.mem_addr); end
        step();
        io.flush = 0; io.ld_valid = 0;
        mid();
        n_tests++; if (io.ld_done !== 1'b0) begin n_fail++; $display("FAIL flush.killed_done got %0b want 0", io.ld_done); end
        n_tests++; if ({io.mem_write, io.mem_addr, io.sq_count} !== {1'b1, 32'h900, 3'd0}) begin n_fail++; $display("FAIL flush.store_drains got w=%0b a=%h cnt=%0d want 1/900/0", io.mem_write, io.mem_addr, io.sq_count); end
        step();
        mid();
        n_tests++; if (io.ld_done !== 1'b0) begin n_fail++; $display("FAIL flush.late_done got %0b want 0", io.ld_done); end
    endtask

    task automatic test_full();
        step();
        io2.ld_valid = 1; io2.ld_addr = 32'hA00;
        io2.st_valid = 1; io2.st_addr = 32'hB00; io2.st_data = 32'h1;
        mid();
        step(); io2.st_addr = 32'hB04; io2.st_data = 32'h2; mid();
        step(); io2.st_addr = 32'hB08; io2.st_data = 32'h3; mid();
        step(); io2.st_addr = 32'hB0C; io2.st_data = 32'h4; mid();
        n_tests++; if (io2.ld_ready !== 1'b1) begin n_fail++; $display("FAIL full.cnt3_ld_ready got %0b want 1", io2.ld_ready); end
        step();
        io2.st_addr = 32'hBF0; io2.st_data = 32'hBAD;
        mid();
        n_tests++; if ({io2.st_ready, io2.sq_count} !== {1'b0, 3'd4}) begin n_fail++; $display("FAIL full.st_ready got rdy=%0b cnt=%0d want 0/4", io2.st_ready, io2.sq_count); end
        n_tests++; if (io2.ld_ready !== 1'b0) begin n_fail++; $display("FAIL full.ld_ready got %0b want 0", io2.ld_ready); end
        step();
        io2.st_valid = 0; io2.ld_valid = 0;
        mid();
        n_tests++; if ({io2.st_ready, io2.sq_count} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL full.reopen got rdy=%0b cnt=%0d want 1/3", io2.st_ready, io2.sq_count); end
        n_tests++; if ({io2.mem_write, io2.mem_addr} !== {1'b1, 32'hB00}) begin n_fail++; $display("FAIL full.head got w=%0b a=%h want 1/b00", io2.mem_write, io2.mem_addr); end
        step(); step(); step();
        mid();
        n_tests++; if ({io2.mem_write, io2.mem_addr, io2.mem_wdata, io2.sq_count} !== {1'b1, 32'hB0C, 32'h4, 3'd0}) begin n_fail++; $display("FAIL full.tail got w=%0b a=%h d=%h cnt=%0d want 1/b0c/4/0", io2.mem_write, io2.mem_addr, io2.mem_wdata, io2.sq_count); end
        step();
        mid();
        n_tests++; if ({io2.mem_write, io2.sq_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL full.overflow_dropped got w=%0b cnt=%0d want 0/0", io2.mem_write, io2.sq_count); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load_only();
        test_loads_over_stores();
        test_drain_thresh();
        test_conflict();
        test_flush();
        test_full();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between speculative loads from the load/store unit and committed stores released by the ROB.
- Committed stores wait in a small in-order store queue.
- Loads normally win the port. Stores drain when the port is idle, when the queue nears full, or when a queued store aliases the pending load.
- Sits between the LS execute stage / ROB commit and the memory-side pipeline register.

Parameters:
- SQ_DEPTH, 4: store queue entries (power of two, ≥2).
- DRAIN_THRESH, 3: occupancy at or above which stores take priority over loads (1..SQ_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; kills pending and in-flight loads
- ld_valid  in  1  load request present
- ld_addr  in  32  load byte address
- ld_func3  in  3  load size/sign
- ld_phy  in  8  destination physical register
- ld_inst_num  in  32  load instruction number
- ld_ready  out  1  load granted this cycle (combinational)
- st_valid  in  1  ROB commits a store
- st_addr  in  32  store byte address
- st_data  in  32  store data
- st_func3  in  3  store size
- st_inst_num  in  32  store instruction number
- st_ready  out  1  queue can accept (registered-count based)
- mem_read  out  1  registered read strobe
- mem_write  out  1  registered write strobe
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered write data
- mem_func3  out  3  registered size
- mem_rdata  in  32  read data, valid the cycle after mem_read
- ld_done  out  1  load result valid
- ld_done_phy  out  8  tag of completing load
- ld_done_inst_num  out  32  instruction number of completing load
- ld_done_data  out  32  equals mem_rdata when ld_done=1
- sq_count  out  $clog2(SQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset: queue empty, sq_count=0, all mem_* = 0, ld_done/ld_done_phy/ld_done_inst_num = 0. Reset overrides every other input.
- Enqueue: st_valid && st_ready writes {addr, data, func3, inst_num} at the tail.
  - st_ready = (sq_count < SQ_DEPTH).
  - When full, a same-cycle dequeue does not admit an enqueue.
  - st_valid while full is a protocol error; it is ignored and the queue is unchanged.
- Conflict: conflict = ld_valid && any valid queue entry has addr[31:2] == ld_addr[31:2].
- Arbitration, one grant per cycle, evaluated in this priority order:
  - 1) flush: no load grant; a store may still issue.
  - 2) sq_count ≥ DRAIN_THRESH or conflict: issue the head store if queue non-empty.
  - 3) ld_valid: grant the load (ld_ready=1).
  - 4) queue non-empty: issue the head store.
  - 5) idle.
- Stores issued under rule 2 never starve loads permanently. Each such cycle drains one entry; the conflict clears once the aliasing entry retires.
- Timing of a grant in cycle t:
  - t+1: mem_read or mem_write = 1, with mem_addr/mem_wdata/mem_func3 set. The store's head entry is popped at the end of t.
  - Idle cycle: strobes = 0, other mem_* hold their last values.
- Load completion: a load granted at t asserts ld_done at t+2 with the latched phy/inst_num. ld_done_data = mem_rdata (combinational pass-through). ld_done is a one-cycle pulse.
- Flush in cycle c:
  - Suppresses ld_done in c+1 and c+2.
  - mem_read already issued may still occur; its data is discarded.
  - Store queue and store issue are unaffected, because committed stores are architectural.
- Ordering: stores leave in commit order. A load never reads a word that has an older queued store to it.
- sq_count updates the cycle after an enqueue/dequeue; simultaneous enqueue+dequeue leaves it unchanged.
- Pointers wrap modulo SQ_DEPTH.

Test Plan:
- Reset then idle → all outputs 0, st_ready=1, sq_count=0.
- Load only: ld_valid, addr 0x100, phy 0x12 at t → ld_ready=1 at t; mem_read=1, mem_addr=0x100 at t+1; ld_done=1, phy 0x12, data = mem_rdata at t+2.
- Queue 2 stores (0x200, 0x204), then continuous loads to 0x300 → loads granted every cycle. Stores issue only in idle cycles. Order 0x200 before 0x204.
- Fill to 3 entries with loads pending (DRAIN_THRESH=3) → next grant is a store, ld_ready=0. Load granted once sq_count drops to 2.
- Store to 0x400 queued, load to 0x402 → ld_ready=0 until the store issues. Load granted the following cycle. mem_write precedes mem_read.
- Load granted at t, flush at t+1 → no ld_done at t+2. Queued stores still drain. Fill to SQ_DEPTH → st_ready=0; one drain → st_ready=1 next cycle.
